// File: rtl/add64_cla_pkg.sv
// Shared constants and result type for the 64-bit carry-lookahead adder.
package add64_cla_pkg;

  localparam int ADD_WIDTH   = 64;
  localparam int BLK_W       = 4;
  localparam int GRP_W       = 16;
  localparam int NUM_BLK     = ADD_WIDTH / BLK_W;
  localparam int NUM_GRP     = ADD_WIDTH / GRP_W;
  localparam int BLK_PER_GRP = GRP_W / BLK_W;

  // Everything the adder registers on a clock edge.
  typedef struct packed {
    logic [ADD_WIDTH-1:0] sum;
    logic                 cout;
    logic                 pg;
    logic                 gg;
  } add_res_t;

endpackage

// File: rtl/add64_cla_cla4.sv
// 4-wide lookahead unit. Used at the bit level on per-bit p/g and at the
// group and top levels on block/group P/G; the maths is identical.
module add64_cla_cla4
  import add64_cla_pkg::*;
(
  input  logic [BLK_W-1:0] p_i,
  input  logic [BLK_W-1:0] g_i,
  input  logic             c_i,
  output logic [BLK_W-1:1] c_o,
  output logic             bp_o,
  output logic             bg_o
);

  // Flattened lookahead equations; no carry ripples through c_o.
  always_comb begin
    c_o[1] = g_i[0] | (p_i[0] & c_i);
    c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & c_i);
    bp_o   = &p_i;
    bg_o   = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
  end

endmodule

// File: rtl/add64_cla.sv
// 64-bit two-level carry-lookahead adder with registered sum, carry-out and
// group propagate/generate (for cascading into a wider lookahead tree).
module add64_cla
  import add64_cla_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pg,
  output logic             gg
);

  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   g;
  logic [WIDTH-1:0]   c;      // carry into each bit
  logic [NUM_BLK-1:0] blk_p;
  logic [NUM_BLK-1:0] blk_g;
  logic [NUM_BLK-1:0] blk_c;  // carry into each 4-bit block
  logic [NUM_GRP-1:0] grp_p;
  logic [NUM_GRP-1:0] grp_g;
  logic [NUM_GRP-1:0] grp_c;  // carry into each 16-bit group
  logic               top_p;
  logic               top_g;
  add_res_t           res_d;
  add_res_t           res_q;

  assign p = a ^ b;
  assign g = a & b;

  // Bit level: each block gets its carry-in from its group's lookahead unit.
  for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_blk
    add64_cla_cla4 u_blk (
      .p_i  (p[gi*BLK_W +: BLK_W]),
      .g_i  (g[gi*BLK_W +: BLK_W]),
      .c_i  (blk_c[gi]),
      .c_o  (c[gi*BLK_W+1 +: BLK_W-1]),
      .bp_o (blk_p[gi]),
      .bg_o (blk_g[gi])
    );
    assign c[gi*BLK_W] = blk_c[gi];
  end

  // Group level: four blocks per group, carry-in from the top unit.
  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
    add64_cla_cla4 u_grp (
      .p_i  (blk_p[gi*BLK_PER_GRP +: BLK_PER_GRP]),
      .g_i  (blk_g[gi*BLK_PER_GRP +: BLK_PER_GRP]),
      .c_i  (grp_c[gi]),
      .c_o  (blk_c[gi*BLK_PER_GRP+1 +: BLK_PER_GRP-1]),
      .bp_o (grp_p[gi]),
      .bg_o (grp_g[gi])
    );
    assign blk_c[gi*BLK_PER_GRP] = grp_c[gi];
  end

  // Top level: its P/G are the whole-word pg/gg, independent of cin.
  add64_cla_cla4 u_top (
    .p_i  (grp_p),
    .g_i  (grp_g),
    .c_i  (cin),
    .c_o  (grp_c[NUM_GRP-1:1]),
    .bp_o (top_p),
    .bg_o (top_g)
  );
  assign grp_c[0] = cin;

  // Assemble the next result from the lookahead carries.
  always_comb begin
    res_d      = '0;
    res_d.sum  = p ^ c;
    res_d.cout = top_g | (top_p & cin);
    res_d.pg   = top_p;
    res_d.gg   = top_g;
  end

  // Output register; reset discards whatever was sampled on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign sum  = res_q.sum;
  assign cout = res_q.cout;
  assign pg   = res_q.pg;
  assign gg   = res_q.gg;

endmodule

// File: tb/tb_add64_cla.sv
// Bench for add64_cla: directed literal vectors plus randomized vectors
// checked every cycle against an arithmetic reference model.
module tb_add64_cla;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a, b;
  logic        cin;
  logic [63:0] sum;
  logic        cout, pg, gg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  add64_cla dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .pg    (pg),
    .gg    (gg)
  );

  // Reference model: plain wide arithmetic, captured on each rising edge.
  logic [63:0] exp_sum;
  logic        exp_cout, exp_pg, exp_gg;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    logic [64:0] ab;
    logic [64:0] full;
    if (!rst_n) begin
      exp_sum = '0; exp_cout = 1'b0; exp_pg = 1'b0; exp_gg = 1'b0;
    end else begin
      ab       = {1'b0, a} + {1'b0, b};
      full     = ab + {64'd0, cin};
      exp_sum  = full[63:0];
      exp_cout = full[64];
      exp_pg   = ((a ^ b) == {64{1'b1}});
      exp_gg   = ab[64];
    end
    model_valid = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      tests++;
      if ({sum, cout, pg, gg} !== {exp_sum, exp_cout, exp_pg, exp_gg}) begin
        fails++;
        $display("FAIL model: got sum=%h cout=%b pg=%b gg=%b, need sum=%h cout=%b pg=%b gg=%b",
                 sum, cout, pg, gg, exp_sum, exp_cout, exp_pg, exp_gg);
      end
    end
  end

  // Drive one cycle of inputs (called at a falling edge), wait one cycle.
  task automatic apply(input logic r, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci);
    rst_n = r; a = av; b = bv; cin = ci;
    @(negedge clk);
  endtask

  // Compare outputs against hand-computed literals; one line per transaction.
  task automatic check_lit(input string name, input logic [63:0] es, input logic ec,
                           input logic ep, input logic eg);
    tests++;
    if ({sum, cout, pg, gg} !== {es, ec, ep, eg}) begin
      fails++;
      $display("FAIL %s: got sum=%h cout=%b pg=%b gg=%b, need sum=%h cout=%b pg=%b gg=%b",
               name, sum, cout, pg, gg, es, ec, ep, eg);
    end else begin
      $display("[TB] %s: sum=%h cout=%b pg=%b gg=%b", name, sum, cout, pg, gg);
    end
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] ra, rb;
    int          mode;

    // Reset held two cycles with inputs that would otherwise carry out.
    apply(1'b0, ONES, ONES, 1'b1);
    check_lit("reset_cyc1", 64'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, ONES, ONES, 1'b1);
    check_lit("reset_cyc2", 64'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, ONES, ONES, 1'b1);
    check_lit("first_after_reset", ONES, 1'b1, 1'b0, 1'b1);

    // Full-propagate chains with and without carry-in.
    apply(1'b1, 64'd0, ONES, 1'b0);
    check_lit("prop_cin0", ONES, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 64'd0, ONES, 1'b1);
    check_lit("prop_cin1", 64'd0, 1'b1, 1'b1, 1'b0);

    // Maximum operands.
    apply(1'b1, ONES, ONES, 1'b0);
    check_lit("max_cin0", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
    apply(1'b1, ONES, ONES, 1'b1);
    check_lit("max_cin1", ONES, 1'b1, 1'b0, 1'b1);

    // Carry rippling through every lookahead level.
    apply(1'b1, 64'd1, ONES, 1'b0);
    check_lit("one_plus_max", 64'd0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b0);
    check_lit("pattern_wrap", 64'd0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 64'h1111_1111_1111_1111, 64'hEEEE_EEEE_EEEE_EEEE, 1'b0);
    check_lit("nibble_prop", ONES, 1'b0, 1'b1, 1'b0);

    // Back-to-back, one result per cycle.
    apply(1'b1, 64'h1000_0000_0000_0000, 64'h0000_1000_0000_0000, 1'b0);
    check_lit("b2b_0", 64'h1000_1000_0000_0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 64'h0000_1000_0000_0000, 64'h0000_0000_1000_0000, 1'b0);
    check_lit("b2b_1", 64'h0000_1000_1000_0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 64'h0000_0000_0000_1000, 64'd1, 1'b0);
    check_lit("b2b_2", 64'h0000_0000_0000_1001, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream drops the operation sampled on that edge.
    apply(1'b0, ONES, 64'd1, 1'b1);
    check_lit("midstream_reset", 64'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 64'd5, 64'd6, 1'b1);
    check_lit("after_mid_reset", 64'd12, 1'b0, 1'b0, 1'b0);

    // Randomized vectors, biased so pg and gg are both exercised.
    for (int i = 0; i < 10000; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      mode = int'($urandom_range(0, 3));
      case (mode)
        1:       rb = ~ra;
        2:       rb = -ra;
        3:       begin ra = 64'd1 << $urandom_range(0, 63); rb = ONES; end
        default: ;
      endcase
      apply(1'b1, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add64_cla.md
Name: add64_cla

Overview:
- 64-bit two-level carry-lookahead adder with carry-in, carry-out and group propagate/generate outputs.
- Outputs are registered.
- Serves as the integer add datapath stage.
- Group P/G outputs allow cascading into a wider lookahead tree.

Parameters:
- WIDTH, 64, operand width; fixed at 64, must be a multiple of 16; other values not supported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- a  input  64  operand A.
- b  input  64  operand B.
- cin  input  1  carry into bit 0.
- sum  output  64  registered (a + b + cin) mod 2^64.
- cout  output  1  registered carry out of bit 63.
- pg  output  1  registered group propagate: 1 iff every bit position propagates, p_i = a_i XOR b_i for all i.
- gg  output  1  registered group generate: 1 iff a + b ≥ 2^64, independent of cin.

Behaviour:
- Per bit: p_i = a_i ^ b_i, g_i = a_i & b_i.
- 4-bit CLA blocks compute block P/G and internal carries.
- Four 4-bit blocks form a 16-bit group with a lookahead unit.
- Four 16-bit groups form the 64-bit top with a lookahead unit.
- No ripple between blocks; carry into each block comes from the lookahead unit.
- sum_i = p_i ^ c_i, with c_0 = cin.
- cout = gg | (pg & cin); it must equal bit 64 of a + b + cin.
- pg = 1 implies gg = 0; both cannot be 1.
- Latency: 1 cycle.
  - a, b, cin are sampled at rising edge N.
  - Results appear on the outputs after edge N and hold until the next edge.
  - A new operation is accepted every cycle; no handshake, no stall.
- Reset: on a rising edge with rst_n = 0, sum = 0, cout = 0, pg = 0, gg = 0.
  - Inputs on that edge are discarded.
  - First valid result appears one edge after rst_n returns high.
  - Reset asserted mid-stream drops the in-flight result.
- Overflow wraps modulo 2^64. No signed-overflow flag is produced; callers derive it from operand MSBs and sum.
- Inputs with X/Z values are unsupported. No internal checks.

Decomposition:
- Shared package: constant ADD_WIDTH = 64, CLA block width = 4, group width = 16.
- One natural sub-module: cla4.
  - Inputs: 4-bit p, 4-bit g, carry-in.
  - Outputs: 3 internal carries, block P, block G.
- Instantiate cla4 for:
  - 16 bit-level blocks,
  - 4 group-level lookahead units,
  - 1 top lookahead unit.
- Top level holds per-bit P/G logic, sum XORs and output registers.

Test Plan:
- rst_n=0 for 2 cycles with a=b=all ones, cin=1 -> sum=0, cout=0, pg=0, gg=0. Release reset -> next edge gives sum=FFFF_FFFF_FFFF_FFFF, cout=1, pg=0, gg=1.
- cin=0, a=0, b=FFFF_FFFF_FFFF_FFFF -> one cycle later sum=FFFF_FFFF_FFFF_FFFF, cout=0, pg=1, gg=0. Same with cin=1 -> sum=0, cout=1, pg=1, gg=0.
- cin=0, a=b=FFFF_FFFF_FFFF_FFFF -> sum=FFFF_FFFF_FFFF_FFFE, cout=1, pg=0, gg=1. With cin=1 -> sum=FFFF_FFFF_FFFF_FFFF, cout=1.
- cin=0, a=0000_0000_0000_0001, b=FFFF_FFFF_FFFF_FFFF -> sum=0, cout=1, gg=1, pg=0. Also cin=0, a=0123_4567_89AB_CDEF, b=FEDC_BA98_7654_3211 -> sum=0, cout=1, pg=0, gg=1.
- cin=0, a=1111_1111_1111_1111, b=EEEE_EEEE_EEEE_EEEE -> sum=FFFF_FFFF_FFFF_FFFF, cout=0, pg=1, gg=0.
- Back-to-back cycles, cin=0:
  - a=1000_0000_0000_0000, b=0000_1000_0000_0000;
  - then a=0000_1000_0000_0000, b=0000_0000_1000_0000;
  - then a=0000_0000_0000_1000, b=1.
  - Expected sums one cycle apart: 1000_1000_0000_0000, 0000_1000_1000_0000, 0000_0000_0000_1001; all cout=0, pg=0, gg=0.
  - Follow with 10k random vectors checked against a+b+cin, with pg/gg checked against the reference definitions.
